// File: rtl/gray_to_bin_seq_pkg.sv
// Shared definitions for the sequential Gray-to-binary decoder: FSM state
// encodings and the default word width also used by the encoder bench.
package gray_to_bin_seq_pkg;

    localparam int GRAY_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/gray_to_bin_seq_step_check.sv
// Combinational step checker: err is high unless a and b differ in exactly
// one bit position (a legal single Gray step).
module gray_step_check #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             err
);

    logic [WIDTH-1:0] w_diff;
    int unsigned      w_cnt;

    assign w_diff = a ^ b;

    always_comb begin
        w_cnt = 0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt = w_cnt + {31'd0, w_diff[i]};
        end
    end

    assign err = (w_cnt != 1);

endmodule

// File: rtl/gray_to_bin_seq.sv
// Sequential Gray-to-binary decoder: accepts one Gray word per handshake,
// decodes it MSB-first one bit per clock and presents it on a valid/ready port.
module gray_to_bin_seq
    import gray_to_bin_seq_pkg::*;
#(
    parameter int WIDTH      = GRAY_W,
    parameter bit CHECK_STEP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] gray_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] bin_out,
    output logic             step_err,
    output logic             busy
);

    localparam int IDXW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDXW-1:0] IDX_START = (WIDTH > 1) ? IDXW'(WIDTH - 2) : '0;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_g;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_prev_gray;
    logic [WIDTH-1:0]  r_bin;
    logic [IDXW-1:0]   r_idx;
    logic              r_step_flag;
    logic              r_prev_vld;
    logic              r_step_err;
    logic [WIDTH-1:0]  w_acc_upd;
    logic              w_dist_err;
    logic              w_step_flag;
    logic              w_accept;
    logic              w_last;

    gray_step_check #(.WIDTH(WIDTH)) u_step_check (
        .a   (gray_in),
        .b   (r_prev_gray),
        .err (w_dist_err)
    );

    assign w_step_flag = CHECK_STEP && r_prev_vld && w_dist_err;
    assign w_accept    = in_valid && (r_state == ST_IDLE);
    assign w_last      = (r_state == ST_SHIFT) && (r_idx == '0);

    // Accumulator with the bit at r_idx resolved; the MSB always equals the
    // Gray MSB, so it is re-asserted here rather than carried separately.
    always_comb begin
        w_acc_upd            = r_acc;
        w_acc_upd[WIDTH-1]   = r_g[WIDTH-1];
        for (int i = 0; i < WIDTH - 1; i++) begin
            if (r_idx == IDXW'(i)) begin
                w_acc_upd[i] = r_acc[i+1] ^ r_g[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (WIDTH > 1) ? ST_SHIFT : ST_HOLD;
                end
            end
            ST_SHIFT: begin
                if (r_idx == '0) begin
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_g         <= '0;
            r_acc       <= '0;
            r_idx       <= '0;
            r_step_flag <= 1'b0;
            r_prev_gray <= '0;
            r_prev_vld  <= 1'b0;
            r_bin       <= '0;
            r_step_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_g                <= gray_in;
                r_acc[WIDTH-1]     <= gray_in[WIDTH-1];
                r_idx              <= IDX_START;
                r_step_flag        <= w_step_flag;
                r_prev_gray        <= gray_in;
                r_prev_vld         <= 1'b1;
                // A single-bit word needs no shifting: publish it straight away.
                if (WIDTH == 1) begin
                    r_bin      <= gray_in;
                    r_step_err <= w_step_flag;
                end
            end
            if (r_state == ST_SHIFT) begin
                r_acc <= w_acc_upd;
                if (r_idx != '0) begin
                    r_idx <= r_idx - IDXW'(1);
                end
            end
            if (w_last) begin
                r_bin      <= w_acc_upd;
                r_step_err <= r_step_flag;
            end
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_HOLD);
    assign busy      = (r_state != ST_IDLE);
    assign bin_out   = r_bin;
    assign step_err  = r_step_err;

endmodule

// File: tb/tb_gray_to_bin_seq.sv
// Scoreboard bench for gray_to_bin_seq: stimulus pushes expected words into a
// queue, an independent monitor pops and compares on every output handshake.
module tb_gray_to_bin_seq;

    typedef struct packed {
        logic [3:0] bin;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] gray_in = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] bin_out;
    logic       step_err;
    logic       busy;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc_cyc = 0;
    exp_t q[$];
    exp_t mon_e;
    logic [3:0] m_prev = 4'd0;
    bit   m_prev_vld = 1'b0;
    bit   bp_en = 1'b0;
    bit   force_ready = 1'b1;
    bit   prev_ov = 1'b0;

    gray_to_bin_seq #(.WIDTH(4), .CHECK_STEP(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .gray_in   (gray_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bin_out   (bin_out),
        .step_err  (step_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1 out_ready = bp_en ? 1'($urandom_range(0, 1)) : force_ready;
    end

    // Binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [3:0] g2b(input logic [3:0] g);
        logic [3:0] r = 4'd0;
        for (int s = 0; s < 4; s++) r = r ^ (g >> s);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_ov <= 1'b0;
        end else begin
            if (out_valid && !prev_ov) check("latency", 32'(cyc - acc_cyc), 32'd3);
            prev_ov <= out_valid;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got bin %0h with empty queue", bin_out);
                end else begin
                    mon_e = q.pop_front();
                    check("bin_out", 32'(bin_out), 32'(mon_e.bin));
                    check("step_err", 32'(step_err), 32'(mon_e.err));
                end
            end
        end
    end

    task automatic send(input logic [3:0] g);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready=%0b want 1", in_ready);
            return;
        end
        in_valid = 1'b1;
        gray_in  = g;
        e.bin = g2b(g);
        e.err = m_prev_vld && ($countones(g ^ m_prev) != 1);
        q.push_back(e);
        m_prev     = g;
        m_prev_vld = 1'b1;
        @(posedge clk);
        #1 acc_cyc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!(q.size() == 0 && in_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!(q.size() == 0 && in_ready)) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: pending=%0d in_ready=%0b want 0/1", q.size(), in_ready);
        end
    endtask

    initial begin
        logic [3:0] b0;
        logic       e0;
        logic [3:0] g;
        int         n;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_bin_out", 32'(bin_out), 32'd0);
        check("rst_step_err", 32'(step_err), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // count sequence, then distance-2 and distance-0 steps
        send(4'b0000); send(4'b0001); send(4'b0011); send(4'b0010);
        send(4'b0111); send(4'b0111);
        // decode spot values, then wrap 1000 -> 0000
        send(4'b1101); send(4'b1000); send(4'b0000);
        // round-trip sweep over the encoder's output sequence
        for (int b = 0; b < 16; b++) send(4'(b ^ (b >> 1)));
        wait_idle();

        // back-pressure in HOLD with a competing input
        force_ready = 1'b0;
        send(4'b0100);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("hold_reached", 32'(out_valid), 32'd1);
        b0 = bin_out;
        e0 = step_err;
        check("hold_bin", 32'(b0), 32'(g2b(4'b0100)));
        in_valid = 1'b1;
        gray_in  = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_bin_stable", 32'(bin_out), 32'(b0));
            check("hold_err_stable", 32'(step_err), 32'(e0));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        force_ready = 1'b1;
        wait_idle();

        // reset while SHIFT is at idx=1
        send(4'b0110);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_bin_out", 32'(bin_out), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        q.delete();
        m_prev_vld = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        send(4'b0101);
        wait_idle();

        // randomized traffic with random back-pressure
        bp_en = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 2) != 0) g = m_prev ^ 4'(1 << $urandom_range(0, 3));
            else g = 4'($urandom);
            send(g);
        end
        wait_idle();
        bp_en = 1'b0;
        repeat (3) @(negedge clk);
        check("final_queue_empty", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
